// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and defaults for the instruction fetch sequencer
package fetch_pkg;

    localparam int TIMEOUT_CYCLES_DEFAULT = 64;

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        WAIT_RESP,
        HOLD,
        DISCARD,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/timeout_counter.sv
// rtl/timeout_counter.sv - saturating wait counter with clear, enable and terminal-count flags
module timeout_counter #(
    parameter int MAX_COUNT = 64,
    localparam int W = $clog2(MAX_COUNT + 1)
) (
    input  logic clk,
    input  logic sync_rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc,
    output logic at_max
);

    localparam logic [W-1:0] MAX_V  = W'(MAX_COUNT);
    localparam logic [W-1:0] LAST_V = W'(MAX_COUNT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!sync_rst_n || clear) begin
            count <= '0;
        end else if (enable && (count != MAX_V)) begin
            count <= count + 1'b1;
        end
    end

    // tc fires in the cycle whose increment lands on MAX_COUNT.
    assign tc     = enable && (count == LAST_V);
    assign at_max = (count == MAX_V);

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch control FSM with redirect, stall and request timeout
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic sync_rst_n,
    input  logic stall_H,
    input  logic redirect_E,
    input  logic imem_req_ready,
    input  logic imem_resp_valid,
    output logic imem_req_valid,
    output logic enable_fetch_H,
    output logic flush_D,
    output logic instr_valid_F,
    output logic fetch_timeout
);

    fetch_state_t state, next_state;
    logic timeout_q;
    logic req_c, en_c, flush_c, iv_c;
    logic cnt_clear, cnt_en, cnt_tc, cnt_at_max, expire;

    always_ff @(posedge clk) begin
        if (!sync_rst_n) begin
            state     <= BOOT;
            timeout_q <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == HALT) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Counter restarts only when a request is accepted, not on redirect into DISCARD.
    assign cnt_clear = (state == REQ) && (next_state == WAIT_RESP);
    assign cnt_en    = ((state == WAIT_RESP) || (state == DISCARD)) && !imem_resp_valid;
    assign expire    = cnt_tc || cnt_at_max;

    timeout_counter #(
        .MAX_COUNT (TIMEOUT_CYCLES)
    ) u_timeout_counter (
        .clk        (clk),
        .sync_rst_n (sync_rst_n),
        .clear      (cnt_clear),
        .enable     (cnt_en),
        .tc         (cnt_tc),
        .at_max     (cnt_at_max)
    );

    always_comb begin
        next_state = state;
        req_c      = 1'b0;
        en_c       = 1'b0;
        flush_c    = 1'b0;
        iv_c       = 1'b0;
        case (state)
            BOOT: begin
                next_state = REQ;
            end
            REQ: begin
                if (redirect_E) begin
                    en_c    = 1'b1;
                    flush_c = 1'b1;
                end else if (!stall_H) begin
                    req_c = 1'b1;
                    if (imem_req_ready) begin
                        next_state = WAIT_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                if (redirect_E) begin
                    en_c    = 1'b1;
                    flush_c = 1'b1;
                    if (imem_resp_valid) begin
                        next_state = REQ;
                    end else if (expire) begin
                        next_state = HALT;
                    end else begin
                        next_state = DISCARD;
                    end
                end else if (imem_resp_valid) begin
                    iv_c = 1'b1;
                    if (stall_H) begin
                        next_state = HOLD;
                    end else begin
                        en_c       = 1'b1;
                        next_state = REQ;
                    end
                end else if (expire) begin
                    next_state = HALT;
                end
            end
            HOLD: begin
                if (redirect_E) begin
                    en_c       = 1'b1;
                    flush_c    = 1'b1;
                    next_state = REQ;
                end else if (stall_H) begin
                    iv_c = 1'b1;
                end else begin
                    en_c       = 1'b1;
                    next_state = REQ;
                end
            end
            DISCARD: begin
                if (redirect_E) begin
                    en_c    = 1'b1;
                    flush_c = 1'b1;
                end
                if (imem_resp_valid) begin
                    next_state = REQ;
                end else if (expire) begin
                    next_state = HALT;
                end
            end
            HALT: begin
                next_state = HALT;
            end
            default: begin
                next_state = BOOT;
            end
        endcase
    end

    // Outputs are forced low whenever reset is asserted, even mid-request.
    assign imem_req_valid = sync_rst_n && req_c;
    assign enable_fetch_H = sync_rst_n && en_c;
    assign flush_D        = sync_rst_n && flush_c;
    assign instr_valid_F  = sync_rst_n && iv_c;
    assign fetch_timeout  = sync_rst_n && timeout_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - table-driven check of fetch_sequencer plus timeout sequence
module tb_fetch_sequencer;

    logic clk = 1'b0;
    logic sync_rst_n = 1'b0;
    logic stall_H = 1'b0;
    logic redirect_E = 1'b0;
    logic imem_req_ready = 1'b0;
    logic imem_resp_valid = 1'b0;

    logic q_req, q_en, q_flush, q_iv, q_to;
    logic r_req, r_en, r_flush, r_iv, r_to;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk             (clk),
        .sync_rst_n      (sync_rst_n),
        .stall_H         (stall_H),
        .redirect_E      (redirect_E),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_req_valid  (q_req),
        .enable_fetch_H  (q_en),
        .flush_D         (q_flush),
        .instr_valid_F   (q_iv),
        .fetch_timeout   (q_to)
    );

    fetch_sequencer #(.TIMEOUT_CYCLES(4)) dut4 (
        .clk             (clk),
        .sync_rst_n      (sync_rst_n),
        .stall_H         (stall_H),
        .redirect_E      (redirect_E),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_req_valid  (r_req),
        .enable_fetch_H  (r_en),
        .flush_D         (r_flush),
        .instr_valid_F   (r_iv),
        .fetch_timeout   (r_to)
    );

    // inputs {rst_n, stall, redirect, ready, resp}; expected {req, en, flush, iv, timeout}
    typedef struct packed {
        logic [4:0] stim;
        logic [4:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic [4:0] s, input logic [4:0] e);
        vec_t t;
        t.stim = s;
        t.exp  = e;
        return t;
    endfunction

    task automatic cyc(input logic [4:0] s, input logic [4:0] e, input bit use4, input string nm);
        logic [4:0] got;
        @(posedge clk);
        #1;
        {sync_rst_n, stall_H, redirect_E, imem_req_ready, imem_resp_valid} = s;
        #4;
        if (use4) got = {r_req, r_en, r_flush, r_iv, r_to};
        else      got = {q_req, q_en, q_flush, q_iv, q_to};
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL %s: got req,en,flush,iv,to=%b want %b", nm, got, e);
        end
    endtask

    vec_t tbl[36];

    initial begin
        tbl[0]  = mk(5'b00000, 5'b00000); // reset
        tbl[1]  = mk(5'b10010, 5'b00000); // BOOT
        tbl[2]  = mk(5'b10010, 5'b10000); // request accepted
        tbl[3]  = mk(5'b10000, 5'b00000);
        tbl[4]  = mk(5'b10001, 5'b01010); // response, no stall
        tbl[5]  = mk(5'b10000, 5'b10000); // REQ, not ready
        tbl[6]  = mk(5'b10010, 5'b10000);
        tbl[7]  = mk(5'b11001, 5'b00010); // response under stall
        tbl[8]  = mk(5'b11000, 5'b00010);
        tbl[9]  = mk(5'b11000, 5'b00010);
        tbl[10] = mk(5'b10000, 5'b01000); // stall drops
        tbl[11] = mk(5'b11010, 5'b00000); // REQ stalled
        tbl[12] = mk(5'b10010, 5'b10000);
        tbl[13] = mk(5'b10100, 5'b01100); // redirect while waiting
        tbl[14] = mk(5'b10000, 5'b00000);
        tbl[15] = mk(5'b10000, 5'b00000);
        tbl[16] = mk(5'b10000, 5'b00000);
        tbl[17] = mk(5'b10001, 5'b00000); // stale response dropped
        tbl[18] = mk(5'b10000, 5'b10000);
        tbl[19] = mk(5'b10110, 5'b01100); // redirect in REQ
        tbl[20] = mk(5'b10010, 5'b10000);
        tbl[21] = mk(5'b10101, 5'b01100); // redirect with response
        tbl[22] = mk(5'b10010, 5'b10000);
        tbl[23] = mk(5'b10100, 5'b01100);
        tbl[24] = mk(5'b10100, 5'b01100); // second redirect in DISCARD
        tbl[25] = mk(5'b10000, 5'b00000);
        tbl[26] = mk(5'b10101, 5'b01100); // redirect with response in DISCARD
        tbl[27] = mk(5'b10000, 5'b10000);
        tbl[28] = mk(5'b10010, 5'b10000);
        tbl[29] = mk(5'b11001, 5'b00010);
        tbl[30] = mk(5'b11100, 5'b01100); // redirect in HOLD
        tbl[31] = mk(5'b10000, 5'b10000);
        tbl[32] = mk(5'b10010, 5'b10000);
        tbl[33] = mk(5'b00001, 5'b00000); // reset mid-request
        tbl[34] = mk(5'b10001, 5'b00000); // response in BOOT ignored
        tbl[35] = mk(5'b10000, 5'b10000);

        for (int i = 0; i < 36; i++) begin
            cyc(tbl[i].stim, tbl[i].exp, 1'b0, $sformatf("vec%0d", i));
        end

        cyc(5'b00000, 5'b00000, 1'b1, "to_reset");
        cyc(5'b10000, 5'b00000, 1'b1, "to_boot");
        cyc(5'b10010, 5'b10000, 1'b1, "to_req");
        for (int w = 0; w < 4; w++) begin
            cyc(5'b10000, 5'b00000, 1'b1, $sformatf("to_wait%0d", w));
        end
        cyc(5'b10000, 5'b00001, 1'b1, "to_halt");
        cyc(5'b11111, 5'b00001, 1'b1, "to_halt_ign1");
        cyc(5'b10111, 5'b00001, 1'b1, "to_halt_ign2");
        cyc(5'b00000, 5'b00000, 1'b1, "to_clr_reset");
        cyc(5'b10000, 5'b00000, 1'b1, "to_clr_boot");
        cyc(5'b10000, 5'b10000, 1'b1, "to_clr_req");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
